// File: rtl/move_entry_controller.sv
// Move entry controller: collects a file/rank/file/rank key sequence from
// PS/2 set-2 scan bytes, arms on four keys, issues the move to the square
// decoder on Enter and waits for ack/reject or auto-aborts after a timeout.
//
// Handshake: scan_code is consumed on any rising edge where scan_valid=1
// (no back-pressure). While move_valid=1 the presented move is held until
// the game logic raises move_ack or move_reject for one cycle; either
// response (or the timeout) retires the move on that edge.
module move_entry_controller #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  input  logic       move_ack,
  input  logic       move_reject,
  output logic [7:0] key1,
  output logic [7:0] key2,
  output logic [7:0] key3,
  output logic [7:0] key4,
  output logic       dec_en,
  output logic       move_valid,
  output logic [2:0] key_count,
  output logic       move_err,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ARMED   = 2'd1,
    ISSUE   = 2'd2
  } state_t;

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_ENTER = 8'h5A;
  localparam logic [7:0] CODE_BKSP  = 8'h66;
  localparam logic [7:0] CODE_ESC   = 8'h76;

  state_t      state_q, state_d;
  logic [7:0]  keys_q [4];
  logic [7:0]  keys_d [4];
  logic [2:0]  count_q, count_d;
  logic        brk_q, brk_d;
  logic [23:0] tcnt_q, tcnt_d;
  logic        err_q, err_d;

  logic        byte_ok;
  logic        timeout;
  logic [1:0]  last_idx;

  function automatic logic is_file(input logic [7:0] c);
    case (c)
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_rank(input logic [7:0] c);
    case (c)
      8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // State, key storage, break flag and timeout counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      for (int i = 0; i < 4; i++) keys_q[i] <= 8'h00;
      count_q <= 3'd0;
      brk_q   <= 1'b0;
      tcnt_q  <= 24'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < 4; i++) keys_q[i] <= keys_d[i];
      count_q <= count_d;
      brk_q   <= brk_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: break/extended prefix filtering, then per-state key handling.
  always_comb begin
    state_d = state_q;
    for (int i = 0; i < 4; i++) keys_d[i] = keys_q[i];
    count_d  = count_q;
    brk_d    = brk_q;
    tcnt_d   = tcnt_q;
    err_d    = 1'b0;
    byte_ok  = 1'b0;
    last_idx = count_q[1:0] - 2'd1;
    // The counter reaches TIMEOUT_CYCLES on this edge.
    timeout  = ({1'b0, tcnt_q} + 25'd1) >= {1'b0, TIMEOUT_CYCLES};

    // E0 is transparent; a byte following F0 is swallowed in every state.
    if (scan_valid) begin
      if (scan_code == CODE_EXT) begin
        byte_ok = 1'b0;
      end else if (brk_q) begin
        brk_d = 1'b0;
      end else if (scan_code == CODE_BREAK) begin
        brk_d = 1'b1;
      end else begin
        byte_ok = 1'b1;
      end
    end

    case (state_q)
      COLLECT: begin
        if (byte_ok) begin
          if (scan_code == CODE_ESC) begin
            for (int i = 0; i < 4; i++) keys_d[i] = 8'h00;
            count_d = 3'd0;
          end else if (scan_code == CODE_BKSP) begin
            if (count_q != 3'd0) begin
              keys_d[last_idx] = 8'h00;
              count_d = count_q - 3'd1;
            end
          end else if ((!count_q[0] && is_file(scan_code)) ||
                       ( count_q[0] && is_rank(scan_code))) begin
            keys_d[count_q[1:0]] = scan_code;
            count_d = count_q + 3'd1;
            if (count_q == 3'd3) state_d = ARMED;
          end
        end
      end

      ARMED: begin
        if (byte_ok) begin
          if (scan_code == CODE_ESC) begin
            for (int i = 0; i < 4; i++) keys_d[i] = 8'h00;
            count_d = 3'd0;
            state_d = COLLECT;
          end else if (scan_code == CODE_ENTER) begin
            tcnt_d  = 24'd0;
            state_d = ISSUE;
          end else if (scan_code == CODE_BKSP) begin
            keys_d[3] = 8'h00;
            count_d   = 3'd3;
            state_d   = COLLECT;
          end
        end
      end

      ISSUE: begin
        // Reject beats ack; ack beats a coincident timeout.
        if (move_ack || move_reject || timeout) begin
          for (int i = 0; i < 4; i++) keys_d[i] = 8'h00;
          count_d = 3'd0;
          tcnt_d  = 24'd0;
          err_d   = move_reject || !move_ack;
          state_d = COLLECT;
        end else begin
          tcnt_d = tcnt_q + 24'd1;
        end
      end

      default: state_d = COLLECT;
    endcase
  end

  assign key1       = keys_q[0];
  assign key2       = keys_q[1];
  assign key3       = keys_q[2];
  assign key4       = keys_q[3];
  assign key_count  = count_q;
  assign dec_en     = (state_q == ISSUE);
  assign move_valid = (state_q == ISSUE);
  assign move_err   = err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_move_entry_controller.sv
// Bench for move_entry_controller: directed move-entry scenarios followed by
// randomized scan/ack/reject/reset traffic, all checked against a queue-based
// model of the entry rules.
module tb_move_entry_controller;

  localparam int TMO = 8;

  logic       clk;
  logic       rst;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       move_ack;
  logic       move_reject;
  logic [7:0] key1, key2, key3, key4;
  logic       dec_en;
  logic       move_valid;
  logic [2:0] key_count;
  logic       move_err;
  logic [1:0] state_dbg;

  move_entry_controller #(.TIMEOUT_CYCLES(24'(TMO))) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .move_ack   (move_ack),
    .move_reject(move_reject),
    .key1       (key1),
    .key2       (key2),
    .key3       (key3),
    .key4       (key4),
    .dec_en     (dec_en),
    .move_valid (move_valid),
    .key_count  (key_count),
    .move_err   (move_err),
    .state_dbg  (state_dbg)
  );

  // Clock and initial input values
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: the move is a queue of entered keys.
  logic [7:0] m_keys[$];
  bit         m_issued;
  bit         m_brk;
  int         m_wait;
  bit         m_err;

  logic [7:0] file_codes [8] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33};
  logic [7:0] rank_codes [8] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};

  function automatic bit in_set(input logic [7:0] c, input bit files);
    for (int i = 0; i < 8; i++)
      if ((files ? file_codes[i] : rank_codes[i]) == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge(input logic v, input logic [7:0] c, input logic a,
                            input logic r, input logic rs);
    bit usable;
    if (rs) begin
      m_keys.delete(); m_issued = 0; m_brk = 0; m_wait = 0; m_err = 0;
      return;
    end
    m_err  = 0;
    usable = 0;
    if (v) begin
      if (c == 8'hE0) usable = 0;
      else if (m_brk) m_brk = 0;
      else if (c == 8'hF0) m_brk = 1;
      else usable = 1;
    end
    if (m_issued) begin
      if (a || r || (m_wait + 1 >= TMO)) begin
        m_err = r || !a;
        m_keys.delete();
        m_issued = 0;
      end else begin
        m_wait++;
      end
    end else if (usable) begin
      if (c == 8'h76) m_keys.delete();
      else if (c == 8'h66) begin
        if (m_keys.size() > 0) void'(m_keys.pop_back());
      end else if (m_keys.size() == 4) begin
        if (c == 8'h5A) begin m_issued = 1; m_wait = 0; end
      end else if (in_set(c, (m_keys.size() % 2) == 0)) begin
        m_keys.push_back(c);
      end
    end
  endtask

  function automatic logic [7:0] exp_key(input int i);
    return (i < m_keys.size()) ? m_keys[i] : 8'h00;
  endfunction

  // Driver: apply inputs for one clock, advance the model, compare after the edge.
  task automatic step(input logic v, input logic [7:0] c, input logic a,
                      input logic r, input logic rs);
    scan_valid = v; scan_code = c; move_ack = a; move_reject = r; rst = rs;
    @(posedge clk);
    model_edge(v, c, a, r, rs);
    #1;
    check("key1", 32'(key1), 32'(exp_key(0)));
    check("key2", 32'(key2), 32'(exp_key(1)));
    check("key3", 32'(key3), 32'(exp_key(2)));
    check("key4", 32'(key4), 32'(exp_key(3)));
    check("key_count", 32'(key_count), 32'(m_keys.size()));
    check("dec_en", 32'(dec_en), 32'(m_issued));
    check("move_valid", 32'(move_valid), 32'(m_issued));
    check("move_err", 32'(move_err), 32'(m_err));
  endtask

  task automatic send(input logic [7:0] c);
    step(1'b1, c, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_list(input logic [7:0] seq[$]);
    foreach (seq[i]) send(seq[i]);
  endtask

  initial begin
    scan_valid = 0; scan_code = 0; move_ack = 0; move_reject = 0; rst = 1;
    m_issued = 0; m_brk = 0; m_wait = 0; m_err = 0;

    // Reset state
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("rst_count", 32'(key_count), 32'd0);
    check("rst_dec_en", 32'(dec_en), 32'd0);

    // Full move then ack
    send_list('{8'h1C, 8'h16, 8'h24, 8'h2E, 8'h5A});
    check("m31_keys", {key1, key2, key3, key4}, 32'h1C16242E);
    check("m31_valid", 32'(move_valid), 32'd1);
    idle();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("m31_cleared", {key1, key2, key3, key4}, 32'h0);
    check("m31_err", 32'(move_err), 32'd0);

    // Release byte swallowed; misplaced rank ignored
    send_list('{8'h1C, 8'hF0, 8'h1C, 8'h16});
    check("m32_keys", {key1, key2}, 32'h1C16);
    check("m32_count", 32'(key_count), 32'd2);
    send(8'h76);
    send(8'h16);
    check("m32_lead_rank", 32'(key_count), 32'd0);

    // Backspace out of ARMED, re-enter rank, issue
    send_list('{8'h1C, 8'h16, 8'h24, 8'h2E, 8'h66});
    check("m33_key4", 32'(key4), 32'h00);
    check("m33_count", 32'(key_count), 32'd3);
    send_list('{8'hE0, 8'h3E, 8'h5A});
    check("m33_key4_new", 32'(key4), 32'h3E);
    check("m33_issue", 32'(move_valid), 32'd1);

    // Ack and reject together: reject wins
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    check("m34_both_err", 32'(move_err), 32'd1);
    idle();
    check("m34_err_once", 32'(move_err), 32'd0);

    // Timeout after TMO cycles in ISSUE
    send_list('{8'h33, 8'h3E, 8'h32, 8'h1E, 8'h5A});
    for (int i = 0; i < TMO - 1; i++) idle();
    check("m34_still_valid", 32'(move_valid), 32'd1);
    idle();
    check("m34_tmo_err", 32'(move_err), 32'd1);
    check("m34_tmo_valid", 32'(move_valid), 32'd0);
    idle();

    // Reset mid-ISSUE with scan and ack active
    send_list('{8'h21, 8'h26, 8'h23, 8'h25, 8'h5A});
    step(1'b1, 8'h76, 1'b1, 1'b1, 1'b1);
    check("m35_valid", 32'(move_valid), 32'd0);
    check("m35_err", 32'(move_err), 32'd0);
    check("m35_key1", 32'(key1), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic [7:0] c;
      r = int'($urandom_range(0, 99));
      if (r < 35)      c = file_codes[$urandom_range(0, 7)];
      else if (r < 70) c = rank_codes[$urandom_range(0, 7)];
      else if (r < 80) c = 8'h5A;
      else if (r < 85) c = 8'h66;
      else if (r < 88) c = 8'h76;
      else if (r < 92) c = 8'hF0;
      else if (r < 95) c = 8'hE0;
      else             c = 8'($urandom_range(0, 255));
      step(($urandom_range(0, 9) < 8), c,
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 13) == 0),
           ($urandom_range(0, 299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
